// File: rtl/uart_tx_feeder.sv
// Purpose: byte FIFO plus launcher FSM that feeds frames to the UART transmitter.
// Latency: a word written to an empty, idle feeder at edge N launches at edge N+1.
// Backpressure: full/almost_full flag the host; writes while full are dropped and set overflow.
module uart_tx_feeder #(
    parameter int DBIT      = 8,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 12
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr_en,
    input  logic [DBIT-1:0] wr_data,
    output logic            full,
    output logic            almost_full,
    output logic [ADDR_W:0] level,
    output logic            overflow,
    input  logic            clr_ovf,
    input  logic            flush,
    input  logic            tx_enable,
    output logic            tx_start,
    output logic [DBIT-1:0] tx_dout,
    input  logic            tx_done_tick,
    output logic            busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_L    = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DBIT-1:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              overflow_q, overflow_d;
    logic              tx_start_q, tx_start_d;
    logic [DBIT-1:0]   tx_dout_q, tx_dout_d;

    logic wr_ok;
    logic wr_drop;
    logic launch;

    // Flags decode straight from the registered level, so a same-cycle pop never admits a write.
    assign full        = (level_q == DEPTH_L);
    assign almost_full = (level_q >= AF_L);
    assign level       = level_q;
    assign overflow    = overflow_q;
    assign tx_start    = tx_start_q;
    assign tx_dout     = tx_dout_q;
    assign busy        = (state_q == WAIT);

    assign wr_ok   = wr_en & ~full & ~flush;
    assign wr_drop = wr_en & full & ~flush;
    assign launch  = tx_enable & (level_q != '0) & ~flush &
                     ((state_q == IDLE) | ((state_q == WAIT) & tx_done_tick));

    // Storage array has no reset; contents are only read below the level count.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Next-state for pointers, level, overflow, launch outputs and FSM.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        tx_start_d = 1'b0;
        tx_dout_d  = tx_dout_q;
        state_d    = state_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (launch) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            case ({wr_ok, launch})
                2'b10:   level_d = level_q + ONE_L;
                2'b01:   level_d = level_q - ONE_L;
                default: level_d = level_q;
            endcase
        end

        // A drop in the same cycle as a clear keeps the flag set.
        if (wr_drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end

        if (launch) begin
            tx_start_d = 1'b1;
            tx_dout_d  = mem_q[rd_ptr_q];
        end

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (tx_done_tick && !launch) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; async reset returns the feeder to idle with empty queue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_dout_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            tx_start_q <= tx_start_d;
            tx_dout_q  <= tx_dout_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Purpose: directed self-checking bench for uart_tx_feeder with a small transmitter model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: bench honours full when generating random writes.
module tb_uart_tx_feeder;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       almost_full;
    logic [4:0] level;
    logic       overflow;
    logic       clr_ovf;
    logic       flush;
    logic       tx_enable;
    logic       tx_start;
    logic [7:0] tx_dout;
    logic       tx_done_tick;
    logic       busy;

    int total = 0;
    int bad   = 0;

    uart_tx_feeder #(.DBIT(8), .ADDR_W(4), .AF_THRESH(12)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .almost_full  (almost_full),
        .level        (level),
        .overflow     (overflow),
        .clr_ovf      (clr_ovf),
        .flush        (flush),
        .tx_enable    (tx_enable),
        .tx_start     (tx_start),
        .tx_dout      (tx_dout),
        .tx_done_tick (tx_done_tick),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic frame_done();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp8;
    int         cnt;
    int         sent;
    int         got;
    int         cyc;
    int         starts;

    initial begin
        reset_n      = 1'b0;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        clr_ovf      = 1'b0;
        flush        = 1'b0;
        tx_enable    = 1'b0;
        tx_done_tick = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_dout", tx_dout, 0);
        reset_n = 1'b1;
        tick();

        // Single byte, first-launch latency
        tx_enable = 1'b1;
        push(8'hA5);
        chk("s_lvl1", level, 1);
        chk("s_nostart", tx_start, 0);
        tick();
        chk("s_start", tx_start, 1);
        chk("s_dout", tx_dout, 8'hA5);
        chk("s_busy", busy, 1);
        chk("s_lvl0", level, 0);
        tick();
        chk("s_pulse1", tx_start, 0);
        repeat (5) tick();
        chk("s_busy_hold", busy, 1);
        chk("s_dout_hold", tx_dout, 8'hA5);
        frame_done();
        chk("s_idle", busy, 0);
        chk("s_nolaunch", tx_start, 0);

        // Burst of three, back-to-back launches
        tx_enable = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        chk("b_lvl3", level, 3);
        chk("b_held", tx_start, 0);
        tx_enable = 1'b1;
        tick();
        chk("b_start0", tx_start, 1);
        chk("b_dout0", tx_dout, 8'h11);
        chk("b_lvl2", level, 2);
        for (int f = 1; f < 3; f++) begin
            repeat (19) tick();
            chk("b_quiet", tx_start, 0);
            frame_done();
            chk("b_start", tx_start, 1);
            chk("b_dout", tx_dout, (f == 1) ? 8'h22 : 8'h33);
            chk("b_lvl", level, 2 - f);
            chk("b_busy", busy, 1);
        end
        repeat (19) tick();
        frame_done();
        chk("b_idle", busy, 0);
        chk("b_end", tx_start, 0);

        // Full / almost_full / overflow with launcher gated off
        tx_enable = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            push(8'(k - 1));
            chk("f_lvl", level, (k > 16) ? 16 : k);
            chk("f_af", almost_full, (k >= 12) ? 1 : 0);
            chk("f_full", full, (k >= 16) ? 1 : 0);
            chk("f_ovf", overflow, (k == 17) ? 1 : 0);
        end
        wr_en   = 1'b1;
        clr_ovf = 1'b1;
        tick();
        chk("f_setwins", overflow, 1);
        wr_en = 1'b0;
        tick();
        chk("f_clr", overflow, 0);
        clr_ovf = 1'b0;
        tx_enable = 1'b1;
        tick();
        chk("f_start0", tx_start, 1);
        chk("f_dout0", tx_dout, 0);
        chk("f_notfull", full, 0);
        for (int j = 1; j < 16; j++) begin
            repeat (3) tick();
            frame_done();
            chk("f_start", tx_start, 1);
            chk("f_dout", tx_dout, j);
        end
        repeat (3) tick();
        frame_done();
        chk("f_idle", busy, 0);
        chk("f_empty", level, 0);

        // tx_enable dropped mid-frame, then a done pulse while idle
        tx_enable = 1'b0;
        push(8'hA1);
        push(8'hA2);
        tx_enable = 1'b1;
        tick();
        chk("e_start", tx_start, 1);
        chk("e_dout", tx_dout, 8'hA1);
        tx_enable = 1'b0;
        repeat (2) tick();
        frame_done();
        chk("e_idle", busy, 0);
        chk("e_nostart", tx_start, 0);
        chk("e_lvl", level, 1);
        frame_done();
        chk("e_idle_done", busy, 0);
        chk("e_idle_nostart", tx_start, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("e_flush", level, 0);

        // Flush mid-frame with a same-cycle write
        for (int k = 0; k < 5; k++) push(8'h50 + 8'(k));
        tx_enable = 1'b1;
        tick();
        chk("x_start", tx_start, 1);
        chk("x_lvl4", level, 4);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h99;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        chk("x_lvl0", level, 0);
        chk("x_busy", busy, 1);
        chk("x_ovf", overflow, 0);
        chk("x_dout", tx_dout, 8'h50);
        repeat (3) tick();
        frame_done();
        chk("x_idle", busy, 0);
        starts = 0;
        for (int k = 0; k < 8; k++) begin
            if (tx_start) starts++;
            tick();
        end
        chk("x_nostart", starts, 0);

        // Random words with concurrent write and pop, pointer wrap
        q.delete();
        sent = 0;
        got  = 0;
        cyc  = 0;
        cnt  = 0;
        tx_enable = 1'b1;
        while ((got < 40 || busy) && cyc < 3000) begin
            tick();
            cyc++;
            if (tx_start) begin
                if (q.size() == 0) begin
                    chk("w_extra", 1, 0);
                end else begin
                    exp8 = q.pop_front();
                    chk("w_order", tx_dout, exp8);
                end
                got++;
                cnt = $urandom_range(2, 8);
            end
            chk("w_lvlmax", {31'b0, level > 5'd16}, 0);
            if (tx_done_tick) begin
                tx_done_tick = 1'b0;
            end else if (busy && cnt == 0) begin
                tx_done_tick = 1'b1;
            end else if (busy) begin
                cnt--;
            end
            if (sent < 40 && !full && $urandom_range(0, 3) != 0) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom);
                q.push_back(wr_data);
                sent++;
            end else begin
                wr_en = 1'b0;
            end
        end
        wr_en        = 1'b0;
        tx_done_tick = 1'b0;
        chk("w_count", got, 40);
        chk("w_drained", q.size(), 0);
        chk("w_lvl0", level, 0);

        // Async reset in the middle of a frame
        tx_enable = 1'b0;
        push(8'h3C);
        tx_enable = 1'b1;
        tick();
        chk("r_start", tx_start, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("r_busy", busy, 0);
        chk("r_start0", tx_start, 0);
        chk("r_dout0", tx_dout, 0);
        chk("r_lvl0", level, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("r_stay", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
